ppg_phase_sampler: RTL and testbench
====================================

Name: ppg_phase_sampler

Overview:
- Receive-side companion to the laser driver: watches the red/IR laser enables, waits for optics/ADC settling, then averages 2^AVG_LOG2 ADC samples per illuminated phase.
- Pairs one red average with one IR average and hands the pair downstream (SpO2 ratio logic) over a valid/ready interface.
- Flags protocol violations: both lasers on, laser dropped mid-measurement, and results overwritten before transfer.

Parameters:
- ADC_WIDTH, 8: ADC sample width and width of each average output.
- SETTLE_CYCLES, 250_000: clk cycles to wait after a laser rising edge before sampling (5 ms at 50 MHz).
- SAMPLE_DIV, 50_000: clk cycles between consecutive samples; must be >=1.
- AVG_LOG2, 4: log2 of the samples per phase (default 16 samples).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- red_laser  in  1  red laser enable, same clock domain.
- IR_laser  in  1  IR laser enable, same clock domain.
- adc_data  in  ADC_WIDTH  photodiode ADC sample, valid every cycle.
- red_avg  out  ADC_WIDTH  averaged red sample of the current output pair.
- ir_avg  out  ADC_WIDTH  averaged IR sample of the current output pair.
- out_valid  out  1  red_avg/ir_avg pair valid.
- out_ready  in  1  downstream accepts the pair.
- phase_err  out  1  one-cycle pulse on a protocol violation.
- overrun  out  1  one-cycle pulse when an untransferred channel result is overwritten.

Behaviour:
- Reset: every output is 0, state IDLE, counters, accumulator, result registers and done flags cleared. Reset mid-operation aborts immediately and emits no pulse.
- Edge detect: registered copies of red_laser/IR_laser are reset to 0. A rise is input=1 while the previous value was 0.
- IDLE:
  - A rise on exactly one laser latches the channel (red/IR) and moves to SETTLE with settle_cnt=0.
  - Both lasers high in the same cycle: phase_err pulses and the FSM stays in IDLE.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1, go to ACQUIRE with tick_cnt=0, acc=0, n=0.
- ACQUIRE:
  - tick_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - On tick_cnt==0, adc_data is added into acc, which is ADC_WIDTH+AVG_LOG2 bits and never overflows. The first sample is taken on the first ACQUIRE cycle.
  - After the 2^AVG_LOG2-th sample, on the next cycle, the channel result register gets acc>>AVG_LOG2 (truncating). Its done flag is set and the FSM goes to WAIT_OFF.
- Abort:
  - Latched laser low in SETTLE or ACQUIRE, or the other laser going high: phase_err pulses, acc is discarded, the FSM goes to IDLE, and no done flag changes.
  - If the other laser rose, that rise is not re-used; the FSM waits for a fresh rise.
- WAIT_OFF: stay until the latched laser is low, then go to IDLE. A rise of the other laser while in WAIT_OFF with the latched one still high pulses phase_err.
- Overwrite: a channel completing while its done flag is already set overwrites the result and pulses overrun.
- Output stage:
  - When red_done && ir_done && (!out_valid || out_ready), the result registers load into red_avg/ir_avg. out_valid is 1 on the next cycle and both done flags clear in the same cycle.
  - Latency from the second done flag set to out_valid=1 is 1 cycle when the output is free.
  - While out_valid && !out_ready, red_avg/ir_avg/out_valid stay stable.
  - On out_valid && out_ready with no new pair pending, out_valid drops next cycle; red_avg/ir_avg keep their last values.
- Ordering: red/IR completion order is free. A pair is one red plus one IR result, whichever finished first.

Test Plan (overrides SETTLE_CYCLES=4, SAMPLE_DIV=2, AVG_LOG2=2):
1. Constant pair: red phase with adc_data=100, then IR phase with adc_data=200, out_ready=1 -> one out_valid cycle with red_avg=100, ir_avg=200; phase_err and overrun stay 0.
2. Ramp: red phase with samples 10,20,30,40 on the tick cycles, IR phase all 255 -> red_avg=25, ir_avg=255.
3. Drop during SETTLE: red_laser falls 2 cycles after its rise -> phase_err is a single pulse, no done flag; a following full red+IR sequence yields exactly one valid pair.
4. Contention: red_laser and IR_laser rise in the same cycle -> phase_err pulse, FSM stays IDLE, no valid.
5. Backpressure: out_ready=0 after the first pair (50/60), then a second full red+IR sequence (70/80) -> outputs hold 50/60 and no overrun. A third red phase (90) pulses overrun. Raising out_ready -> 50/60 accepted, then the next pair is 90/80.
6. Reset mid-ACQUIRE (rst high for 1 cycle) -> all outputs 0, and no stale result appears after a subsequent clean red+IR sequence (only the new averages).

Source files
------------

// File: rtl/ppg_phase_sampler.sv
// Receive-side PPG sampler: waits for optics to settle after each laser turns on, averages
// 2^AVG_LOG2 ADC samples per phase, and pairs red/IR averages on a valid/ready output.
module ppg_phase_sampler #(
  parameter int ADC_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 250_000,
  parameter int SAMPLE_DIV    = 50_000,
  parameter int AVG_LOG2      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 red_laser,
  input  logic                 IR_laser,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [ADC_WIDTH-1:0] red_avg,
  output logic [ADC_WIDTH-1:0] ir_avg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 phase_err,
  output logic                 overrun
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = ADC_WIDTH + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int NS = 1 << AVG_LOG2;

  typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, WAIT_OFF} state_t;

  state_t                 state, state_nx;
  logic                   red_q, ir_q;
  logic                   ch, ch_nx;          // 0 = red phase, 1 = IR phase
  logic                   red_rise, ir_rise, lat_on, other_rise;
  logic                   start_settle, start_acq, complete, err_d, load;
  logic [SW-1:0]          settle_cnt;
  logic [TW-1:0]          tick_cnt;
  logic [NW-1:0]          n;
  logic [AW-1:0]          acc;
  logic [ADC_WIDTH-1:0]   red_res, ir_res;
  logic                   red_done, ir_done;

  assign red_rise   = red_laser & ~red_q;
  assign ir_rise    = IR_laser & ~ir_q;
  assign lat_on     = ch ? IR_laser : red_laser;
  assign other_rise = ch ? red_rise : ir_rise;

  // Output handshake: out_valid holds red_avg/ir_avg stable until out_ready is seen high;
  // a new pair may load in the same cycle the current one is accepted.
  assign load = red_done && ir_done && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    ch_nx        = ch;
    err_d        = 1'b0;
    start_settle = 1'b0;
    start_acq    = 1'b0;
    complete     = 1'b0;
    case (state)
      IDLE: begin
        if ((red_rise || ir_rise) && red_laser && IR_laser) begin
          err_d = 1'b1;
        end else if (red_rise) begin
          ch_nx = 1'b0; state_nx = SETTLE; start_settle = 1'b1;
        end else if (ir_rise) begin
          ch_nx = 1'b1; state_nx = SETTLE; start_settle = 1'b1;
        end
      end
      SETTLE: begin
        if (!lat_on || other_rise) begin
          err_d = 1'b1; state_nx = IDLE;
        end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
          state_nx = ACQUIRE; start_acq = 1'b1;
        end
      end
      ACQUIRE: begin
        if (!lat_on || other_rise) begin
          err_d = 1'b1; state_nx = IDLE;
        end else if (n == NW'(NS)) begin
          complete = 1'b1; state_nx = WAIT_OFF;
        end
      end
      WAIT_OFF: begin
        if (!lat_on)         state_nx = IDLE;
        else if (other_rise) err_d = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_q <= 1'b0; ir_q <= 1'b0; ch <= 1'b0; phase_err <= 1'b0;
      settle_cnt <= '0; tick_cnt <= '0; n <= '0; acc <= '0;
    end else begin
      red_q     <= red_laser;
      ir_q      <= IR_laser;
      ch        <= ch_nx;
      phase_err <= err_d;
      if (start_settle)          settle_cnt <= '0;
      else if (state == SETTLE)  settle_cnt <= settle_cnt + SW'(1);
      if (start_acq) begin
        tick_cnt <= '0; acc <= '0; n <= '0;
      end else if (state == ACQUIRE) begin
        tick_cnt <= (tick_cnt == TW'(SAMPLE_DIV - 1)) ? '0 : tick_cnt + TW'(1);
        if (tick_cnt == '0 && n != NW'(NS)) begin
          acc <= acc + AW'(adc_data);
          n   <= n + NW'(1);
        end
      end
    end
  end

  // A channel result counts as overwritten only if it was not handed off in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_res <= '0; ir_res <= '0; red_done <= 1'b0; ir_done <= 1'b0;
      red_avg <= '0; ir_avg <= '0; out_valid <= 1'b0; overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        red_avg   <= red_res;
        ir_avg    <= ir_res;
        out_valid <= 1'b1;
        red_done  <= 1'b0;
        ir_done   <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (complete && !ch) begin
        red_res  <= acc[AW-1:AVG_LOG2];
        red_done <= 1'b1;
        overrun  <= red_done && !load;
      end
      if (complete && ch) begin
        ir_res  <= acc[AW-1:AVG_LOG2];
        ir_done <= 1'b1;
        overrun <= ir_done && !load;
      end
    end
  end

endmodule

// File: tb/tb_ppg_phase_sampler.sv
// Bench for ppg_phase_sampler with short settle/sample timing; expected pairs are queued
// as phases are driven and checked when the output handshake completes.
module tb_ppg_phase_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       red_laser = 1'b0;
  logic       ir_laser = 1'b0;
  logic [7:0] adc_data = 8'd0;
  logic       out_ready = 1'b1;
  logic [7:0] red_avg, ir_avg;
  logic       out_valid, phase_err, overrun;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pair;

  ppg_phase_sampler #(
    .ADC_WIDTH(8), .SETTLE_CYCLES(4), .SAMPLE_DIV(2), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .red_laser(red_laser), .IR_laser(ir_laser),
    .adc_data(adc_data), .red_avg(red_avg), .ir_avg(ir_avg),
    .out_valid(out_valid), .out_ready(out_ready),
    .phase_err(phase_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted pair must match the head of the expected queue.
  always @(negedge clk) begin
    if (phase_err) err_pulses++;
    if (overrun)   ovr_pulses++;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pair_unexpected: got red=%0d ir=%0d, required no pair", red_avg, ir_avg);
      end else begin
        exp_pair = exp_q.pop_front();
        if ({red_avg, ir_avg} !== exp_pair) begin
          errors++;
          $display("FAIL pair_value: got red=%0d ir=%0d, required red=%0d ir=%0d",
                   red_avg, ir_avg, exp_pair[15:8], exp_pair[7:0]);
        end
      end
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // One full phase: rise, settle, four samples each held across a SAMPLE_DIV window, laser off.
  task automatic run_phase(input bit is_ir, input logic [7:0] s0, s1, s2, s3);
    if (is_ir) ir_laser = 1'b1; else red_laser = 1'b1;
    step(5);
    adc_data = s0; step(2);
    adc_data = s1; step(2);
    adc_data = s2; step(2);
    adc_data = s3; step(2);
    step(2);
    if (is_ir) ir_laser = 1'b0; else red_laser = 1'b0;
    step(2);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    step(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", out_valid); end
    checks++; if (red_avg !== 8'd0) begin errors++; $display("FAIL reset_red: got %0d, required 0", red_avg); end
    checks++; if (ir_avg !== 8'd0) begin errors++; $display("FAIL reset_ir: got %0d, required 0", ir_avg); end
    checks++; if (phase_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got err=%0b ovr=%0b, required 0 0", phase_err, overrun); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_constant();
    int e0, o0;
    e0 = err_pulses; o0 = ovr_pulses;
    exp_q.push_back({8'd100, 8'd200});
    run_phase(1'b0, 8'd100, 8'd100, 8'd100, 8'd100);
    run_phase(1'b1, 8'd200, 8'd200, 8'd200, 8'd200);
    wait_drain();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL const_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (err_pulses !== e0) begin errors++; $display("FAIL const_err: got %0d pulses, required %0d", err_pulses, e0); end
    checks++; if (ovr_pulses !== o0) begin errors++; $display("FAIL const_ovr: got %0d pulses, required %0d", ovr_pulses, o0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL const_valid_drop: got %0b, required 0", out_valid); end
  endtask

  task automatic test_ramp();
    exp_q.push_back({8'd25, 8'd255});
    run_phase(1'b0, 8'd10, 8'd20, 8'd30, 8'd40);
    run_phase(1'b1, 8'd255, 8'd255, 8'd255, 8'd255);
    wait_drain();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ramp_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_settle_drop();
    int e0;
    logic [7:0] r, v;
    e0 = err_pulses;
    red_laser = 1'b1; step(2);
    red_laser = 1'b0; step(4);
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL drop_err: got %0d pulses, required %0d", err_pulses, e0 + 1); end
    r = 8'($urandom_range(0, 255));
    v = 8'($urandom_range(0, 255));
    exp_q.push_back({r, v});
    run_phase(1'b0, r, r, r, r);
    run_phase(1'b1, v, v, v, v);
    wait_drain();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL drop_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL drop_err_after: got %0d pulses, required %0d", err_pulses, e0 + 1); end
  endtask

  task automatic test_contention();
    int e0;
    e0 = err_pulses;
    red_laser = 1'b1; ir_laser = 1'b1;
    step(8);
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL cont_err: got %0d pulses, required %0d", err_pulses, e0 + 1); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cont_valid: got %0b, required 0", out_valid); end
    red_laser = 1'b0; ir_laser = 1'b0;
    step(2);
  endtask

  task automatic test_backpressure();
    int o0;
    o0 = ovr_pulses;
    out_ready = 1'b0;
    exp_q.push_back({8'd50, 8'd60});
    exp_q.push_back({8'd90, 8'd80});
    run_phase(1'b0, 8'd50, 8'd50, 8'd50, 8'd50);
    run_phase(1'b1, 8'd60, 8'd60, 8'd60, 8'd60);
    checks++; if ({out_valid, red_avg, ir_avg} !== {1'b1, 8'd50, 8'd60}) begin errors++; $display("FAIL bp_first: got v=%0b red=%0d ir=%0d, required 1 50 60", out_valid, red_avg, ir_avg); end
    run_phase(1'b0, 8'd70, 8'd70, 8'd70, 8'd70);
    run_phase(1'b1, 8'd80, 8'd80, 8'd80, 8'd80);
    checks++; if ({out_valid, red_avg, ir_avg} !== {1'b1, 8'd50, 8'd60}) begin errors++; $display("FAIL bp_hold: got v=%0b red=%0d ir=%0d, required 1 50 60", out_valid, red_avg, ir_avg); end
    checks++; if (ovr_pulses !== o0) begin errors++; $display("FAIL bp_no_ovr: got %0d pulses, required %0d", ovr_pulses, o0); end
    run_phase(1'b0, 8'd90, 8'd90, 8'd90, 8'd90);
    checks++; if (ovr_pulses !== o0 + 1) begin errors++; $display("FAIL bp_ovr: got %0d pulses, required %0d", ovr_pulses, o0 + 1); end
    out_ready = 1'b1;
    wait_drain();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %0b, required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int e0, o0;
    logic [7:0] r, v;
    // Leave an IR result pending so a reset that fails to clear it would produce a stale pair.
    run_phase(1'b1, 8'd99, 8'd99, 8'd99, 8'd99);
    red_laser = 1'b1; adc_data = 8'd123;
    step(8);
    e0 = err_pulses; o0 = ovr_pulses;
    rst = 1'b1; red_laser = 1'b0;
    step(1);
    checks++; if ({out_valid, red_avg, ir_avg, phase_err, overrun} !== 19'd0) begin errors++; $display("FAIL rst_mid_outputs: got v=%0b red=%0d ir=%0d err=%0b ovr=%0b, required all 0", out_valid, red_avg, ir_avg, phase_err, overrun); end
    rst = 1'b0;
    step(3);
    checks++; if (err_pulses !== e0) begin errors++; $display("FAIL rst_mid_err: got %0d pulses, required %0d", err_pulses, e0); end
    r = 8'($urandom_range(1, 254));
    v = 8'($urandom_range(1, 254));
    exp_q.push_back({r, v});
    run_phase(1'b0, r, r, r, r);
    run_phase(1'b1, v, v, v, v);
    wait_drain();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_mid_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (ovr_pulses !== o0) begin errors++; $display("FAIL rst_mid_ovr: got %0d pulses, required %0d", ovr_pulses, o0); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_settle_drop();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
